// File: rtl/datamover_s2mm_framer_if.sv
// datamover_s2mm_framer_if: stream, command, frame-data and status buses of the S2MM framer.
//  master: framer side (sample sink, command/data source, status sink).
//  slave : environment side (sample source, datamover command/data/status ports).
interface datamover_s2mm_framer_if;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [71:0] m_axis_s2mm_cmd_tdata;
    logic        m_axis_s2mm_cmd_tvalid;
    logic        m_axis_s2mm_cmd_tready;
    logic [31:0] m_axis_s2mm_tdata;
    logic [3:0]  m_axis_s2mm_tkeep;
    logic        m_axis_s2mm_tlast;
    logic        m_axis_s2mm_tvalid;
    logic        m_axis_s2mm_tready;
    logic [7:0]  s_axis_s2mm_sts_tdata;
    logic        s_axis_s2mm_sts_tvalid;
    logic        s_axis_s2mm_sts_tready;
    modport master (
        input  s_axis_tdata, s_axis_tvalid, m_axis_s2mm_cmd_tready, m_axis_s2mm_tready,
               s_axis_s2mm_sts_tdata, s_axis_s2mm_sts_tvalid,
        output s_axis_tready, m_axis_s2mm_cmd_tdata, m_axis_s2mm_cmd_tvalid, m_axis_s2mm_tdata,
               m_axis_s2mm_tkeep, m_axis_s2mm_tlast, m_axis_s2mm_tvalid, s_axis_s2mm_sts_tready
    );
    modport slave (
        output s_axis_tdata, s_axis_tvalid, m_axis_s2mm_cmd_tready, m_axis_s2mm_tready,
               s_axis_s2mm_sts_tdata, s_axis_s2mm_sts_tvalid,
        input  s_axis_tready, m_axis_s2mm_cmd_tdata, m_axis_s2mm_cmd_tvalid, m_axis_s2mm_tdata,
               m_axis_s2mm_tkeep, m_axis_s2mm_tlast, m_axis_s2mm_tvalid, s_axis_s2mm_sts_tready
    );
endinterface

// File: rtl/datamover_s2mm_framer.sv
// datamover_s2mm_framer: cuts a 32-bit sample stream into fixed frames for the DataMover S2MM channel.
//  clk_in1, aresetn : clock, asynchronous active-low reset
//  enable           : start new frames while high
//  bus              : sample stream in, 72-bit command out, frame data out, status in
//  frame_count      : frames completed with status received
//  sts_err          : sticky status error
//  busy             : FSM outside IDLE
module datamover_s2mm_framer #(
    parameter int unsigned FRAME_WORDS = 128,
    parameter int unsigned NUM_FRAMES  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'hC0000000
) (
    input  logic                           clk_in1,
    input  logic                           aresetn,
    input  logic                           enable,
    datamover_s2mm_framer_if.master        bus,
    output logic [31:0]                    frame_count,
    output logic                           sts_err,
    output logic                           busy
);
    localparam int CW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
    localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
    localparam logic [22:0] BTT = 23'(4 * FRAME_WORDS);
    localparam logic [31:0] STRIDE = 32'(4 * FRAME_WORDS);
    typedef enum logic [1:0] {IDLE, CMD, DATA, STS} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] word_cnt;
    logic [FW-1:0] frame_idx;
    logic [31:0] wr_addr;
    logic [3:0] tag;
    logic in_data, last_word, cmd_hs, data_hs, sts_hs, sts_bad;
    assign tag = 4'(frame_idx);
    assign in_data = state_q == DATA;
    assign last_word = word_cnt == CW'(FRAME_WORDS - 1);
    assign cmd_hs = bus.m_axis_s2mm_cmd_tvalid && bus.m_axis_s2mm_cmd_tready;
    assign data_hs = in_data && bus.s_axis_tvalid && bus.m_axis_s2mm_tready;
    assign sts_hs = state_q == STS && bus.s_axis_s2mm_sts_tvalid;
    // A status beat is bad if OKAY is missing, any error bit is set, or it belongs to another frame.
    assign sts_bad = !bus.s_axis_s2mm_sts_tdata[7] || (|bus.s_axis_s2mm_sts_tdata[6:4])
                     || bus.s_axis_s2mm_sts_tdata[3:0] != tag;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = enable ? CMD : IDLE;
            CMD:     state_d = cmd_hs ? DATA : CMD;
            DATA:    state_d = data_hs && last_word ? STS : DATA;
            default: state_d = sts_hs ? IDLE : STS;
        endcase
        // Zero-latency passthrough while in DATA; everything is quiet otherwise so upstream stalls.
        bus.s_axis_tready          = in_data && bus.m_axis_s2mm_tready;
        bus.m_axis_s2mm_tvalid     = in_data && bus.s_axis_tvalid;
        bus.m_axis_s2mm_tdata      = in_data ? bus.s_axis_tdata : 32'h0;
        bus.m_axis_s2mm_tkeep      = in_data ? 4'hF : 4'h0;
        bus.m_axis_s2mm_tlast      = in_data && last_word;
        bus.s_axis_s2mm_sts_tready = state_q == STS;
        busy                       = state_q != IDLE;
    end
    always_ff @(posedge clk_in1 or negedge aresetn) begin
        if (!aresetn) begin
            state_q                    <= IDLE;
            bus.m_axis_s2mm_cmd_tvalid <= 1'b0;
            bus.m_axis_s2mm_cmd_tdata  <= '0;
            word_cnt                   <= '0;
            frame_idx                  <= '0;
            wr_addr                    <= BASE_ADDR;
            frame_count                <= '0;
            sts_err                    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Command is built while leaving IDLE so cmd_tvalid is a clean register output.
            if (state_q == IDLE && enable) begin
                bus.m_axis_s2mm_cmd_tvalid <= 1'b1;
                bus.m_axis_s2mm_cmd_tdata  <= {4'h0, tag, wr_addr, 1'b0, 1'b1, 6'h0, 1'b1, BTT};
            end else if (cmd_hs) begin
                bus.m_axis_s2mm_cmd_tvalid <= 1'b0;
            end
            if (data_hs)
                word_cnt <= last_word ? '0 : word_cnt + CW'(1);
            if (sts_hs) begin
                sts_err     <= sts_err | sts_bad;
                frame_count <= frame_count + 32'd1;
                if (frame_idx == FW'(NUM_FRAMES - 1)) begin
                    frame_idx <= '0;
                    wr_addr   <= BASE_ADDR;
                end else begin
                    frame_idx <= frame_idx + FW'(1);
                    wr_addr   <= wr_addr + STRIDE;
                end
            end
        end
    end
endmodule

// File: tb/tb_datamover_s2mm_framer.sv
// tb_datamover_s2mm_framer: randomized self-checking bench for datamover_s2mm_framer.
module tb_datamover_s2mm_framer;
    localparam int FW = 128;
    localparam int NF = 8;
    localparam logic [31:0] BASE = 32'hC0000000;
    logic clk_in1 = 1'b0;
    logic aresetn = 1'b0;
    logic enable = 1'b0;
    logic [31:0] frame_count;
    logic sts_err, busy;
    int total = 0;
    int bad = 0;
    int exp_n = 0;
    int exp_count = 0;
    logic exp_err = 1'b0;
    logic [31:0] src_word;
    logic [31:0] exp_q[$];
    datamover_s2mm_framer_if bus();
    datamover_s2mm_framer #(.FRAME_WORDS(FW), .NUM_FRAMES(NF), .BASE_ADDR(BASE)) dut (
        .clk_in1(clk_in1), .aresetn(aresetn), .enable(enable), .bus(bus.master),
        .frame_count(frame_count), .sts_err(sts_err), .busy(busy)
    );
    always #5 clk_in1 = ~clk_in1;

    task automatic check(input string name, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Expected command for the n-th frame since reset, built from the field layout.
    function automatic logic [71:0] exp_cmd(input int n);
        int k = n % NF;
        logic [71:0] c = 72'(k) << 64;
        c = c | (72'(BASE + 32'(k * 4 * FW)) << 32);
        c = c | (72'(1) << 30) | (72'(1) << 23) | 72'(4 * FW);
        return c;
    endfunction

    task automatic zero_inputs();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata = 32'h0;
        bus.m_axis_s2mm_cmd_tready = 1'b0;
        bus.m_axis_s2mm_tready = 1'b0;
        bus.s_axis_s2mm_sts_tvalid = 1'b0;
        bus.s_axis_s2mm_sts_tdata = 8'h0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_tdata"}, bus.m_axis_s2mm_cmd_tdata, 72'(0));
        check({name, "_ctl"}, 72'({bus.m_axis_s2mm_cmd_tvalid, bus.m_axis_s2mm_tvalid, bus.m_axis_s2mm_tlast,
              bus.m_axis_s2mm_tkeep, bus.s_axis_tready, bus.s_axis_s2mm_sts_tready, sts_err, busy}), 72'(0));
        check({name, "_m_tdata"}, 72'(bus.m_axis_s2mm_tdata), 72'(0));
        check({name, "_frame_count"}, 72'(frame_count), 72'(0));
    endtask

    // Called at a falling edge: assert reset mid-cycle, check, release two cycles later.
    task automatic pulse_reset(input string name);
        #2 aresetn = 1'b0;
        #1 check_reset_outputs(name);
        enable = 1'b0;
        zero_inputs();
        exp_n = 0;
        exp_count = 0;
        exp_err = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_in1);
        aresetn = 1'b1;
    endtask

    task automatic run_frame(input int hold, input bit bp, input int sts_code, input int gap,
                             input int drop_at, input int rst_at);
        int cyc = 0;
        int held = 0;
        int beat = 0;
        int dly;
        bit done = 0;
        bit seen = 0;
        logic hs_s, hs_m;
        logic [7:0] sv;
        bus.s_axis_s2mm_sts_tvalid = 1'b1;
        bus.s_axis_s2mm_sts_tdata = 8'h80 | 8'(exp_n % NF);
        while (!done) begin
            @(negedge clk_in1);
            bus.m_axis_s2mm_cmd_tready = held >= hold;
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata = src_word;
            bus.m_axis_s2mm_tready = 1'b1;
            #1;
            check("cmd_quiet", 72'({bus.s_axis_s2mm_sts_tready, bus.s_axis_tready, bus.m_axis_s2mm_tvalid}), 72'(0));
            if (bus.m_axis_s2mm_cmd_tvalid) begin
                if (!seen && gap >= 0) check("cmd_gap", 72'(cyc), 72'(gap));
                seen = 1;
                check("cmd_tdata", bus.m_axis_s2mm_cmd_tdata, exp_cmd(exp_n));
                if (bus.m_axis_s2mm_cmd_tready) done = 1;
                else held++;
            end
            cyc++;
            if (!done && cyc > 40) begin
                check("cmd_timeout", 72'(0), 72'(1));
                return;
            end
            @(posedge clk_in1);
        end
        done = 0;
        cyc = 0;
        while (!done) begin
            @(negedge clk_in1);
            if (beat == rst_at) begin
                pulse_reset("mid_reset");
                return;
            end
            if (beat == drop_at) enable = 1'b0;
            bus.m_axis_s2mm_cmd_tready = 1'($urandom_range(0, 1));
            bus.s_axis_tvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_axis_tdata = src_word;
            bus.m_axis_s2mm_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("data_ctl", 72'({bus.m_axis_s2mm_cmd_tvalid, bus.s_axis_s2mm_sts_tready, bus.s_axis_tready,
                  bus.m_axis_s2mm_tvalid}), 72'({1'b0, 1'b0, bus.m_axis_s2mm_tready, bus.s_axis_tvalid}));
            check("tlast", 72'(bus.m_axis_s2mm_tlast), 72'(beat == FW - 1));
            hs_s = bus.s_axis_tvalid && bus.s_axis_tready;
            hs_m = bus.m_axis_s2mm_tvalid && bus.m_axis_s2mm_tready;
            if (hs_s) exp_q.push_back(src_word);
            if (hs_m) begin
                check("tkeep", 72'(bus.m_axis_s2mm_tkeep), 72'(4'hF));
                if (exp_q.size() == 0) check("data_underflow", 72'(0), 72'(1));
                else check("data_word", 72'(bus.m_axis_s2mm_tdata), 72'(exp_q.pop_front()));
            end
            @(posedge clk_in1);
            if (hs_s) src_word = $urandom;
            if (hs_m) begin
                beat++;
                if (beat == FW) done = 1;
            end
            cyc++;
            if (!done && cyc > 5000) begin
                check("data_timeout", 72'(0), 72'(1));
                return;
            end
        end
        check("queue_empty", 72'(exp_q.size()), 72'(0));
        sv = sts_code < 0 ? 8'h80 | 8'(exp_n % NF) : 8'(sts_code);
        dly = bp ? $urandom_range(0, 3) : 0;
        done = 0;
        cyc = 0;
        while (!done) begin
            @(negedge clk_in1);
            bus.s_axis_s2mm_sts_tvalid = cyc >= dly;
            bus.s_axis_s2mm_sts_tdata = sv;
            bus.s_axis_tvalid = 1'b1;
            bus.m_axis_s2mm_tready = 1'b1;
            #1;
            check("sts_state", 72'({bus.s_axis_s2mm_sts_tready, bus.s_axis_tready, bus.m_axis_s2mm_tvalid,
                  bus.m_axis_s2mm_tlast, busy}), 72'(5'b10001));
            if (bus.s_axis_s2mm_sts_tvalid && bus.s_axis_s2mm_sts_tready) done = 1;
            @(posedge clk_in1);
            cyc++;
            if (!done && cyc > 20) begin
                check("sts_timeout", 72'(0), 72'(1));
                return;
            end
        end
        exp_count++;
        if (!sv[7] || sv[6:4] != 3'b0 || int'(sv[3:0]) != exp_n % NF) exp_err = 1'b1;
        exp_n++;
        #1;
        check("frame_count", 72'(frame_count), 72'(exp_count));
        check("sts_err", 72'(sts_err), 72'(exp_err));
        check("busy_idle", 72'(busy), 72'(0));
        zero_inputs();
    endtask

    initial begin
        zero_inputs();
        src_word = $urandom;
        #3 check_reset_outputs("por");
        @(negedge clk_in1);
        aresetn = 1'b1;
        enable = 1'b1;
        run_frame(0, 0, -1, 0, -1, -1);
        for (int i = 1; i < 9; i++)
            run_frame(i == 1 ? 10 : $urandom_range(0, 3), 1, -1, 1, -1, -1);
        run_frame(0, 1, -1, 1, 50, -1);
        repeat (5) begin
            @(negedge clk_in1);
            #1 check("parked", 72'({busy, bus.m_axis_s2mm_cmd_tvalid}), 72'(0));
        end
        @(negedge clk_in1);
        enable = 1'b1;
        run_frame(0, 1, -1, 0, -1, 50);
        enable = 1'b1;
        run_frame(2, 1, 8'hC0, 0, -1, -1);
        run_frame(0, 1, -1, 1, -1, -1);
        @(negedge clk_in1);
        pulse_reset("between_reset");
        enable = 1'b1;
        run_frame(0, 0, 8'h85, 0, -1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
